// File: rtl/tilelink_pkg.sv
// Shared TL-UL opcode encodings and responder FSM state type.
package tilelink_pkg;

   localparam logic [2:0] PUT_FULL_DATA_A    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL_DATA_A = 3'd1;
   localparam logic [2:0] GET_A              = 3'd4;

   localparam logic [2:0] ACCESS_ACK_D       = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA_D  = 3'd1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

endpackage

// File: rtl/tl_ul_byte_ram.sv
// Word-addressed RAM with per-byte write enables and a combinational read port.
module tl_ul_byte_ram #(
   parameter int MEM_DEPTH  = 256,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int IDX_WIDTH  = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic [STRB_WIDTH-1:0] we_i,
   input  logic [IDX_WIDTH-1:0]  idx_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   // byte-lane writes; contents deliberately have no reset
   always_ff @(posedge clk) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
         if (we_i[b]) begin
            mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/tilelink_ul_mem_slave.sv
// TL-UL memory responder, one outstanding request.
// Define TL_SLAVE_BACK2BACK_EN to accept a new request on the same edge a response completes.
module tilelink_ul_mem_slave
   import tilelink_pkg::*;
#(
   parameter int TL_ADDR_WIDTH   = 64,
   parameter int TL_DATA_WIDTH   = 64,
   parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
   parameter int TL_SOURCE_WIDTH = 3,
   parameter int TL_SINK_WIDTH   = 3,
   parameter int TL_OPCODE_WIDTH = 3,
   parameter int TL_PARAM_WIDTH  = 3,
   parameter int TL_SIZE_WIDTH   = 8,
   parameter int MEM_DEPTH       = 256,
   parameter int SINK_ID         = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       a_valid,
   output logic                       a_ready,
   input  logic [TL_OPCODE_WIDTH-1:0] a_opcode,
   input  logic [TL_PARAM_WIDTH-1:0]  a_param,
   input  logic [TL_ADDR_WIDTH-1:0]   a_address,
   input  logic [TL_SIZE_WIDTH-1:0]   a_size,
   input  logic [TL_STRB_WIDTH-1:0]   a_mask,
   input  logic [TL_DATA_WIDTH-1:0]   a_data,
   input  logic [TL_SOURCE_WIDTH-1:0] a_source,
   output logic                       d_valid,
   input  logic                       d_ready,
   output logic [TL_OPCODE_WIDTH-1:0] d_opcode,
   output logic [TL_PARAM_WIDTH-1:0]  d_param,
   output logic [TL_SIZE_WIDTH-1:0]   d_size,
   output logic [TL_SOURCE_WIDTH-1:0] d_source,
   output logic [TL_SINK_WIDTH-1:0]   d_sink,
   output logic [TL_DATA_WIDTH-1:0]   d_data,
   output logic                       d_denied,
   output logic                       d_corrupt
);

   localparam int OFF_W = $clog2(TL_STRB_WIDTH);
   localparam int IDX_W = $clog2(MEM_DEPTH);

   state_t                     state_q, state_d;
   logic [TL_OPCODE_WIDTH-1:0] d_opcode_q, d_opcode_d;
   logic [TL_SIZE_WIDTH-1:0]   d_size_q, d_size_d;
   logic [TL_SOURCE_WIDTH-1:0] d_source_q, d_source_d;
   logic [TL_DATA_WIDTH-1:0]   d_data_q, d_data_d;
   logic                       d_denied_q, d_denied_d;
   logic                       d_corrupt_q, d_corrupt_d;

   logic [IDX_W-1:0]           idx_s;
   logic [TL_ADDR_WIDTH-1:0]   align_mask_s;
   logic                       err_range_s, err_size_s, err_align_s, err_op_s, err_s;
   logic                       is_put_s, is_get_s, a_ready_s, accept_s;
   logic [TL_STRB_WIDTH-1:0]   we_s;
   logic [TL_DATA_WIDTH-1:0]   rdata_s;
   logic                       unused_param_s;

   // request decode and the four independent error checks
   always_comb begin
      is_put_s     = 1'b0;
      is_get_s     = 1'b0;
      err_op_s     = 1'b0;
      idx_s        = a_address[OFF_W +: IDX_W];
      err_range_s  = |a_address[TL_ADDR_WIDTH-1:OFF_W+IDX_W];
      err_size_s   = (a_size > TL_SIZE_WIDTH'(OFF_W));
      // shifts of TL_ADDR_WIDTH or more give an all-ones mask
      align_mask_s = ~({TL_ADDR_WIDTH{1'b1}} << a_size);
      err_align_s  = |(a_address & align_mask_s);
      case (a_opcode)
         PUT_FULL_DATA_A, PUT_PARTIAL_DATA_A: is_put_s = 1'b1;
         GET_A:                               is_get_s = 1'b1;
         default:                             err_op_s = 1'b1;
      endcase
      err_s = err_range_s | err_size_s | err_align_s | err_op_s;
   end

   // request acceptance
   always_comb begin
      a_ready_s = 1'b0;
      if (rst) begin
         a_ready_s = 1'b0;
      end else begin
`ifdef TL_SLAVE_BACK2BACK_EN
         a_ready_s = (state_q == IDLE) || d_ready;
`else
         a_ready_s = (state_q == IDLE);
`endif
      end
      accept_s = a_valid && a_ready_s;
      we_s     = (accept_s && is_put_s && !err_s) ? a_mask : {TL_STRB_WIDTH{1'b0}};
   end

   tl_ul_byte_ram #(
      .MEM_DEPTH  (MEM_DEPTH),
      .DATA_WIDTH (TL_DATA_WIDTH),
      .STRB_WIDTH (TL_STRB_WIDTH),
      .IDX_WIDTH  (IDX_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (we_s),
      .idx_i   (idx_s),
      .wdata_i (a_data),
      .rdata_o (rdata_s)
   );

   // next state and response field capture
   always_comb begin
      state_d     = state_q;
      d_opcode_d  = d_opcode_q;
      d_size_d    = d_size_q;
      d_source_d  = d_source_q;
      d_data_d    = d_data_q;
      d_denied_d  = d_denied_q;
      d_corrupt_d = d_corrupt_q;
      if (accept_s) begin
         state_d     = RESP;
         d_size_d    = a_size;
         d_source_d  = a_source;
         d_denied_d  = err_s;
         d_opcode_d  = is_get_s ? TL_OPCODE_WIDTH'(ACCESS_ACK_DATA_D) : TL_OPCODE_WIDTH'(ACCESS_ACK_D);
         d_corrupt_d = is_get_s && err_s;
         d_data_d    = (is_get_s && !err_s) ? rdata_s : {TL_DATA_WIDTH{1'b0}};
      end else if ((state_q == RESP) && d_ready) begin
         state_d = IDLE;
      end else begin
         state_d = state_q;
      end
   end

   // state and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         d_opcode_q  <= {TL_OPCODE_WIDTH{1'b0}};
         d_size_q    <= {TL_SIZE_WIDTH{1'b0}};
         d_source_q  <= {TL_SOURCE_WIDTH{1'b0}};
         d_data_q    <= {TL_DATA_WIDTH{1'b0}};
         d_denied_q  <= 1'b0;
         d_corrupt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         d_opcode_q  <= d_opcode_d;
         d_size_q    <= d_size_d;
         d_source_q  <= d_source_d;
         d_data_q    <= d_data_d;
         d_denied_q  <= d_denied_d;
         d_corrupt_q <= d_corrupt_d;
      end
   end

   assign unused_param_s = ^a_param;

   assign a_ready   = a_ready_s;
   assign d_valid   = (state_q == RESP);
   assign d_opcode  = d_opcode_q;
   assign d_param   = {TL_PARAM_WIDTH{1'b0}};
   assign d_size    = d_size_q;
   assign d_source  = d_source_q;
   assign d_sink    = TL_SINK_WIDTH'(SINK_ID);
   assign d_data    = d_data_q;
   assign d_denied  = d_denied_q;
   assign d_corrupt = d_corrupt_q;

endmodule

// File: tb/tb_tilelink_ul_mem_slave.sv
// Self-checking bench: directed scenarios then randomized traffic against an array reference model.
module tb_tilelink_ul_mem_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, a_ready;
   logic [2:0]  a_opcode, a_param, a_source;
   logic [63:0] a_address, a_data;
   logic [7:0]  a_size, a_mask;
   logic        d_valid, d_ready;
   logic [2:0]  d_opcode, d_param, d_source, d_sink;
   logic [7:0]  d_size;
   logic [63:0] d_data;
   logic        d_denied, d_corrupt;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] ref_mem [256];
   logic [63:0] last_data;

   always #5 clk = ~clk;

   tilelink_ul_mem_slave dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
      .a_address(a_address), .a_size(a_size), .a_mask(a_mask), .a_data(a_data),
      .a_source(a_source),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
      .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
      .d_denied(d_denied), .d_corrupt(d_corrupt)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // Reference: applies the access rules to a plain word array.
   task automatic model(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] size,
                        input logic [7:0] mask, input logic [63:0] data,
                        output logic [2:0] e_op, output logic [63:0] e_data,
                        output logic e_den, output logic e_cor);
      bit err;
      int w;
      err = (addr >= 64'd2048) || (size > 8'd3) || !(op == 3'd0 || op == 3'd1 || op == 3'd4);
      if (size >= 8'd64) err = err || (addr != 64'd0);
      else               err = err || ((addr % (64'd1 << size)) != 64'd0);
      w      = int'((addr / 64'd8) % 64'd256);
      e_den  = err;
      e_cor  = err && (op == 3'd4);
      e_op   = (op == 3'd4) ? 3'd1 : 3'd0;
      e_data = 64'd0;
      if (!err && op == 3'd4) e_data = ref_mem[w];
      if (!err && (op == 3'd0 || op == 3'd1)) begin
         for (int b = 0; b < 8; b++) begin
            if (mask[b]) ref_mem[w][b*8 +: 8] = data[b*8 +: 8];
         end
      end
   endtask

   task automatic release_resp();
      d_ready = 1'b1;
      @(posedge clk); #1;
      d_ready = 1'b0;
      check_eq("d_valid_after_handshake", {63'd0, d_valid}, 64'd0);
      check_eq("a_ready_after_handshake", {63'd0, a_ready}, 64'd1);
   endtask

   task automatic do_req(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] size,
                         input logic [7:0] mask, input logic [63:0] data, input logic [2:0] src,
                         input bit hold);
      logic [2:0]  e_op;
      logic [63:0] e_data;
      logic        e_den, e_cor;
      int          n;
      a_valid = 1'b1; a_opcode = op; a_address = addr; a_size = size;
      a_mask = mask; a_data = data; a_source = src; a_param = 3'd0;
      n = 0;
      while (a_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("a_ready_before_accept", {63'd0, a_ready}, 64'd1);
      model(op, addr, size, mask, data, e_op, e_data, e_den, e_cor);
      last_data = e_data;
      @(posedge clk); #1;
      a_valid = 1'b0;
      check_eq("d_valid", {63'd0, d_valid}, 64'd1);
      check_eq("a_ready_in_resp", {63'd0, a_ready}, 64'd0);
      check_eq("d_opcode", {61'd0, d_opcode}, {61'd0, e_op});
      check_eq("d_source", {61'd0, d_source}, {61'd0, src});
      check_eq("d_size", {56'd0, d_size}, {56'd0, size});
      check_eq("d_denied", {63'd0, d_denied}, {63'd0, e_den});
      check_eq("d_corrupt", {63'd0, d_corrupt}, {63'd0, e_cor});
      check_eq("d_data", d_data, e_data);
      check_eq("d_param_sink", {58'd0, d_param, d_sink}, 64'd0);
      if (!hold) release_resp();
   endtask

   initial begin
      logic [2:0]  op, e_op;
      logic [63:0] addr, e_data;
      logic [7:0]  size;
      logic        e_den, e_cor;
      int          sel, stall;

      rst = 1'b1; a_valid = 1'b0; d_ready = 1'b0; a_opcode = 3'd0; a_param = 3'd0;
      a_address = 64'd0; a_size = 8'd0; a_mask = 8'd0; a_data = 64'd0; a_source = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_d_valid", {63'd0, d_valid}, 64'd0);
      check_eq("reset_a_ready", {63'd0, a_ready}, 64'd0);
      check_eq("reset_d_data", d_data, 64'd0);
      rst = 1'b0;
      #1;
      check_eq("post_reset_a_ready", {63'd0, a_ready}, 64'd1);

      for (int w = 0; w < 16; w++) begin
         do_req(3'd0, 64'(w * 8), 8'd3, 8'hFF, {$urandom, $urandom}, 3'(w), 1'b0);
      end

      // directed accesses
      do_req(3'd0, 64'h10, 8'd3, 8'hFF, 64'hCAFEBABE_DEADBEEF, 3'd1, 1'b0);
      do_req(3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd1, 1'b0);
      check_eq("tp2_get_data", last_data, 64'hCAFEBABE_DEADBEEF);
      do_req(3'd1, 64'h10, 8'd3, 8'h0F, 64'h11223344_55667788, 3'd2, 1'b0);
      do_req(3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd2, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_eq("stall_d_valid", {63'd0, d_valid}, 64'd1);
         check_eq("stall_d_data", d_data, 64'hCAFEBABE_55667788);
         check_eq("stall_a_ready", {63'd0, a_ready}, 64'd0);
      end
      release_resp();

      do_req(3'd4, 64'h800, 8'd3, 8'hFF, 64'd0, 3'd3, 1'b0);
      do_req(3'd4, 64'h14, 8'd3, 8'hFF, 64'd0, 3'd4, 1'b0);
      do_req(3'd2, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd5, 1'b0);
      do_req(3'd0, 64'h14, 8'd2, 8'hFF, 64'h0BAD0BAD_0BAD0BAD, 3'd6, 1'b0);
      do_req(3'd4, 64'h10, 8'd4, 8'hFF, 64'd0, 3'd7, 1'b0);
      do_req(3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd0, 1'b0);

      // reset during a pending response drops it
      do_req(3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd5, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_resp_d_valid", {63'd0, d_valid}, 64'd0);
      check_eq("rst_resp_d_opcode", {61'd0, d_opcode}, 64'd0);
      check_eq("rst_resp_d_data", d_data, 64'd0);
      check_eq("rst_resp_a_ready", {63'd0, a_ready}, 64'd0);
      rst = 1'b0;
      #1;
      check_eq("rst_release_a_ready", {63'd0, a_ready}, 64'd1);
      @(posedge clk); #1;

`ifdef TL_SLAVE_BACK2BACK_EN
      d_ready = 1'b1;
      a_valid = 1'b1; a_opcode = 3'd0; a_address = 64'h18; a_size = 8'd3;
      a_mask = 8'hFF; a_data = 64'h0123_4567_89AB_CDEF; a_source = 3'd3;
      model(3'd0, 64'h18, 8'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, e_op, e_data, e_den, e_cor);
      @(posedge clk); #1;
      check_eq("b2b_put_valid", {63'd0, d_valid}, 64'd1);
      check_eq("b2b_a_ready", {63'd0, a_ready}, 64'd1);
      a_opcode = 3'd4; a_source = 3'd4;
      model(3'd4, 64'h18, 8'd3, 8'hFF, 64'd0, e_op, e_data, e_den, e_cor);
      @(posedge clk); #1;
      check_eq("b2b_get_opcode", {61'd0, d_opcode}, 64'd1);
      check_eq("b2b_get_source", {61'd0, d_source}, 64'd4);
      check_eq("b2b_get_data", d_data, e_data);
      a_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("b2b_drain", {63'd0, d_valid}, 64'd0);
      d_ready = 1'b0;
`endif

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 3)      op = 3'd4;
         else if (sel <= 5) op = 3'd0;
         else if (sel <= 7) op = 3'd1;
         else if (sel == 8) op = 3'($urandom_range(2, 3));
         else               op = 3'($urandom_range(5, 7));
         size = 8'($urandom_range(0, 3));
         addr = 64'($urandom_range(0, 15) * 8) + (64'($urandom_range(0, 7)) & ~((64'd1 << size) - 64'd1));
         if ($urandom_range(0, 7) == 0) size = 8'($urandom_range(0, 5));
         if ($urandom_range(0, 9) == 0) addr = 64'($urandom_range(0, 127));
         if ($urandom_range(0, 9) == 0) addr = {$urandom, $urandom} | 64'h800;
         stall = $urandom_range(0, 3);
         do_req(op, addr, size, 8'($urandom), {$urandom, $urandom}, 3'($urandom_range(0, 7)), stall != 0);
         if (stall != 0) begin
            for (int s = 0; s < stall; s++) begin
               @(posedge clk); #1;
               check_eq("rand_stall_valid", {63'd0, d_valid}, 64'd1);
               check_eq("rand_stall_data", d_data, last_data);
            end
            release_resp();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
